// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer between the M stage and cp0: arbitrates interrupt, exception
// and eret, drives the EXL strobes, flushes and redirects, then settles while the pipe refills.
module exc_ctrl #(
    parameter int unsigned SETTLE_CYC  = 2,
    parameter logic [1:0]  HANDLER_SEL = 2'b01,
    parameter logic [1:0]  EPC_SEL     = 2'b10
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       ValidM,
    input  logic       ExcValidM,
    input  logic [6:2] ExcCodeM,
    input  logic       EretM,
    input  logic       IntReq,
    output logic       EXLSet,
    output logic       EXLClr,
    output logic [6:2] ExcCodeOut,
    output logic       FlushAll,
    output logic [1:0] PCSel,
    output logic       Busy,
    output logic [6:2] LastCode,
    output logic [7:0] ExcCount
);

    typedef enum logic {StIdle, StSettle} state_e;

    localparam logic [3:0] CntInit = 4'(SETTLE_CYC - 1);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [6:2] last_code_q, last_code_d;
    logic [7:0] exc_count_q, exc_count_d;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            last_code_q <= 5'd0;
            exc_count_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_code_q <= last_code_d;
            exc_count_q <= exc_count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_code_d = last_code_q;
        exc_count_d = exc_count_q;
        EXLSet      = 1'b0;
        EXLClr      = 1'b0;
        ExcCodeOut  = 5'd0;
        FlushAll    = 1'b0;
        PCSel       = 2'b00;
        Busy        = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Reset also masks the Mealy strobes so a simultaneous request never escapes.
                if (!Reset && ValidM) begin
                    if (IntReq || ExcValidM) begin
                        EXLSet      = 1'b1;
                        FlushAll    = 1'b1;
                        PCSel       = HANDLER_SEL;
                        ExcCodeOut  = IntReq ? 5'd0 : ExcCodeM;
                        last_code_d = ExcCodeOut;
                        if (exc_count_q != 8'hFF) begin
                            exc_count_d = exc_count_q + 8'd1;
                        end
                        state_d     = StSettle;
                        cnt_d       = CntInit;
                    end else if (EretM) begin
                        EXLClr   = 1'b1;
                        FlushAll = 1'b1;
                        PCSel    = EPC_SEL;
                        state_d  = StSettle;
                        cnt_d    = CntInit;
                    end
                end
            end
            StSettle: begin
                Busy = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign LastCode = last_code_q;
    assign ExcCount = exc_count_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl with the default SETTLE_CYC=2 and select codes.
module tb_exc_ctrl;

    logic       Clk = 1'b0;
    logic       Reset, ValidM, ExcValidM, EretM, IntReq;
    logic [6:2] ExcCodeM;
    logic       EXLSet, EXLClr, FlushAll, Busy;
    logic [6:2] ExcCodeOut, LastCode;
    logic [1:0] PCSel;
    logic [7:0] ExcCount;

    int n_checks = 0;
    int n_errors = 0;

    exc_ctrl dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .ValidM     (ValidM),
        .ExcValidM  (ExcValidM),
        .ExcCodeM   (ExcCodeM),
        .EretM      (EretM),
        .IntReq     (IntReq),
        .EXLSet     (EXLSet),
        .EXLClr     (EXLClr),
        .ExcCodeOut (ExcCodeOut),
        .FlushAll   (FlushAll),
        .PCSel      (PCSel),
        .Busy       (Busy),
        .LastCode   (LastCode),
        .ExcCount   (ExcCount)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance past a rising edge; inputs change at +2, checks happen at +3.
    task automatic cyc();
        @(posedge Clk);
        #2;
    endtask

    initial begin
        Reset = 1'b1; ValidM = 1'b0; ExcValidM = 1'b0; ExcCodeM = 5'd0;
        EretM = 1'b0; IntReq = 1'b0;
        cyc(); cyc();
        #1;
        check("rst_busy", Busy, 0);
        check("rst_last", LastCode, 0);
        check("rst_cnt", ExcCount, 0);
        check("rst_pcsel", PCSel, 0);
        check("rst_exlset", EXLSet, 0);
        Reset = 1'b0;
        cyc();

        // Interrupt accepted, two settle cycles, re-accepted on the third.
        IntReq = 1'b1; ValidM = 1'b1; #1;
        check("int_exlset", EXLSet, 1);
        check("int_flush", FlushAll, 1);
        check("int_pcsel", PCSel, 2'b01);
        check("int_code", ExcCodeOut, 0);
        check("int_exlclr", EXLClr, 0);
        cyc(); #1;
        check("int_k1_busy", Busy, 1);
        check("int_k1_exlset", EXLSet, 0);
        check("int_k1_flush", FlushAll, 0);
        check("int_k1_count", ExcCount, 1);
        cyc(); #1;
        check("int_k2_busy", Busy, 1);
        check("int_k2_exlset", EXLSet, 0);
        cyc(); #1;
        check("int_k3_exlset", EXLSet, 1);
        check("int_k3_busy", Busy, 0);
        cyc(); IntReq = 1'b0;
        cyc(); cyc(); #1;
        check("int_idle_busy", Busy, 0);
        check("int_count2", ExcCount, 2);

        // Interrupt beats a simultaneous exception; then a lone exception.
        IntReq = 1'b1; ExcValidM = 1'b1; ExcCodeM = 5'd4; #1;
        check("prio_code", ExcCodeOut, 0);
        cyc(); IntReq = 1'b0; ExcValidM = 1'b0; #1;
        check("prio_last", LastCode, 0);
        check("prio_count", ExcCount, 3);
        cyc(); cyc();
        ExcValidM = 1'b1; ExcCodeM = 5'd12; #1;
        check("exc_code", ExcCodeOut, 12);
        check("exc_exlset", EXLSet, 1);
        cyc(); ExcValidM = 1'b0; #1;
        check("exc_last", LastCode, 12);
        check("exc_count", ExcCount, 4);
        cyc(); cyc();

        // Interrupt waits through bubbles, then is taken when ValidM rises.
        IntReq = 1'b1; ValidM = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bubble_exlset", EXLSet, 0);
            check("bubble_flush", FlushAll, 0);
            check("bubble_busy", Busy, 0);
            cyc();
        end
        ValidM = 1'b1; #1;
        check("bubble_take", EXLSet, 1);
        cyc(); IntReq = 1'b0; #1;
        check("bubble_count", ExcCount, 5);
        cyc(); cyc();

        // eret, then eret held through SETTLE is ignored.
        EretM = 1'b1; #1;
        check("eret_exlclr", EXLClr, 1);
        check("eret_flush", FlushAll, 1);
        check("eret_pcsel", PCSel, 2'b10);
        check("eret_exlset", EXLSet, 0);
        cyc(); #1;
        check("eret_s1_exlclr", EXLClr, 0);
        check("eret_s1_busy", Busy, 1);
        check("eret_count", ExcCount, 5);
        cyc(); #1;
        check("eret_s2_exlclr", EXLClr, 0);
        cyc();

        // Exception on an eret instruction is an exception only.
        ExcValidM = 1'b1; ExcCodeM = 5'd12; #1;
        check("exc_eret_set", EXLSet, 1);
        check("exc_eret_clr", EXLClr, 0);
        check("exc_eret_pcsel", PCSel, 2'b01);
        cyc(); ExcValidM = 1'b0; EretM = 1'b0; #1;
        check("settle1_busy", Busy, 1);
        check("settle1_last", LastCode, 12);
        check("settle1_count", ExcCount, 6);

        // Reset mid-SETTLE, with a simultaneous request pending.
        Reset = 1'b1; IntReq = 1'b1;
        cyc(); #1;
        check("rst2_busy", Busy, 0);
        check("rst2_last", LastCode, 0);
        check("rst2_count", ExcCount, 0);
        check("rst2_exlset", EXLSet, 0);
        check("rst2_flush", FlushAll, 0);
        Reset = 1'b0; #1;
        check("post_rst_take", EXLSet, 1);

        // Back-to-back interrupts: 260 accepts, count saturates at 255.
        for (int i = 0; i < 259; i++) begin
            cyc(); #1;
            if (i == 99) check("sat_count100", ExcCount, 100);
            if (i == 258) check("sat_count259", ExcCount, 255);
            cyc(); cyc(); #1;
            if (EXLSet !== 1'b1) check("b2b_exlset", EXLSet, 1);
            else n_checks++;
        end
        cyc(); #1;
        check("sat_final", ExcCount, 255);
        IntReq = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/exc_ctrl.md
# exc_ctrl

Exception/interrupt sequencing controller between the M pipeline stage and `cp0`. Each cycle it arbitrates among a hardware interrupt (`IntReq` from `cp0`), a synchronous exception raised by the M-stage instruction, and an `eret` in M. It drives `cp0`'s `EXLSet`/`EXLClr` and the exception code, flushes the pipeline and redirects fetch. It then holds off further requests for a programmable settle window while the pipeline refills.

## Interface
Parameters:
- `SETTLE_CYC`, 2: cycles in SETTLE after an accepted event (legal range 1..15).
- `HANDLER_SEL`, 2'b01: `PCSel` code for handler entry (NPC mux selects 0x00004180).
- `EPC_SEL`, 2'b10: `PCSel` code for return (NPC mux selects `cp0` `ePC`).

Ports:
- `Clk`  in  1  system clock, rising edge.
- `Reset`  in  1  synchronous, active-high.
- `ValidM`  in  1  M stage holds a real instruction, not a bubble.
- `ExcValidM`  in  1  M-stage instruction raised a synchronous exception.
- `ExcCodeM`  in  [6:2]  code of that exception.
- `EretM`  in  1  M-stage instruction is `eret`.
- `IntReq`  in  1  level interrupt request from `cp0`, already masked by IM/IE/EXL.
- `EXLSet`  out  1  to `cp0`: capture EPC/Cause, set EXL.
- `EXLClr`  out  1  to `cp0`: clear EXL.
- `ExcCodeOut`  out  [6:2]  code to `cp0` Cause; valid while `EXLSet`=1, else 0.
- `FlushAll`  out  1  flush F/D/E/M pipeline registers at the next edge.
- `PCSel`  out  [1:0]  NPC override: 00 normal, `HANDLER_SEL`, `EPC_SEL`.
- `Busy`  out  1  controller is in SETTLE.
- `LastCode`  out  [6:2]  registered code of the most recent accepted exception or interrupt.
- `ExcCount`  out  [7:0]  saturating count of accepted exceptions and interrupts; `eret` is not counted.

## Operation
- States: IDLE, SETTLE. Settle counter `cnt` [3:0].
- IDLE arbitration is combinational, decided in the same cycle. A request is accepted only if `ValidM`=1. Priority:
  1. `IntReq` takes the event with code 5'd0.
  2. `ExcValidM` takes the event with code `ExcCodeM`.
  3. `EretM` takes the return.
- Accepted interrupt or exception (Mealy, same cycle):
  - `EXLSet`=1, `FlushAll`=1, `PCSel`=`HANDLER_SEL`, `ExcCodeOut`=code.
  - At the edge: `LastCode`<=code, `ExcCount`<=min(`ExcCount`+1, 255), state<=SETTLE, `cnt`<=`SETTLE_CYC`-1.
- Accepted `eret` (same cycle):
  - `EXLClr`=1, `FlushAll`=1, `PCSel`=`EPC_SEL`.
  - At the edge: state<=SETTLE, `cnt`<=`SETTLE_CYC`-1.
- `EXLSet` and `EXLClr` are never asserted in the same cycle. An exception on an `eret` instruction (`ExcValidM`=1 and `EretM`=1) is treated as an exception only.
- No accepted request: all strobes 0, `PCSel`=00, state stays IDLE.
- SETTLE:
  - `Busy`=1; all strobes 0; every input is ignored, with no latching or queueing.
  - If `cnt`==0, go to IDLE at the edge; otherwise `cnt`<=`cnt`-1.
- An interrupt ignored during SETTLE or during bubbles is not lost. `IntReq` is level-held by `cp0` and is re-evaluated in IDLE. A synchronous exception ignored in SETTLE is dropped; this cannot occur in legal flow because M holds flushed bubbles.

## Timing
- Reset (synchronous): state=IDLE, `cnt`=0, `LastCode`=0, `ExcCount`=0. All outputs are 0 at the first edge with `Reset`=1; `PCSel`=00, `Busy`=0.
- `Reset` overrides everything, including mid-SETTLE and a simultaneous request.
- Latency:
  - Request accepted to strobes: 0 cycles (combinational).
  - `LastCode`/`ExcCount` update: 1 edge.
  - SETTLE occupies exactly `SETTLE_CYC` cycles.
  - The earliest next acceptance is `SETTLE_CYC`+1 cycles after the previous one.
- The strobes and `FlushAll` are 1-cycle pulses, one per accepted event.
- `ExcCount` holds at 255; it does not wrap.

## Test plan
- Reset, then `IntReq`=1, `ValidM`=1 in cycle k:
  - In k: `EXLSet`=1, `FlushAll`=1, `PCSel`=01, `ExcCodeOut`=0.
  - k+1..k+2: `Busy`=1, strobes 0.
  - k+3: `EXLSet`=1 again if `IntReq` is still high.
- `IntReq`=1, `ExcValidM`=1, `ExcCodeM`=5'd4 together -> `ExcCodeOut`=0, `LastCode`=0 after the edge. Then `ExcValidM`=1, `ExcCodeM`=5'd12 alone in IDLE -> `ExcCodeOut`=12, `LastCode`=12.
- `IntReq`=1 with `ValidM`=0 for 3 cycles -> no strobes, `Busy`=0. `ValidM` rises -> `EXLSet`=1 in that same cycle.
- `EretM`=1, `ValidM`=1 in IDLE -> `EXLClr`=1, `FlushAll`=1, `PCSel`=10, `EXLSet`=0, `ExcCount` unchanged. `EretM`=1 again during SETTLE -> ignored, `EXLClr`=0.
- `Reset`=1 in the first SETTLE cycle (following a code-12 exception) -> at the next edge `Busy`=0, `LastCode`=0, `ExcCount`=0. `IntReq`=1 in the cycle after `Reset` drops -> accepted immediately.
- 260 back-to-back interrupts -> `ExcCount` stops at 255.
